// File: rtl/demux1_2_buf.sv
// Buffered 1-to-2 valid/ready demultiplexer: sel=1 steers to A, sel=0 to B, each behind its own FIFO.
// Optional beat counters on cnt_a/cnt_b are built only when DEMUX_STATS_EN is defined.
module demux1_2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] outa_data,
  output logic             outa_valid,
  input  logic             outa_ready,
  output logic [WIDTH-1:0] outb_data,
  output logic             outb_valid,
  input  logic             outb_ready,
  output logic [31:0]      cnt_a,
  output logic [31:0]      cnt_b
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Index 1 is output A and index 0 is output B, so in_sel doubles as the FIFO index.
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       valid;
  logic [1:0]       ready;
  logic [WIDTH-1:0] head [2];
  logic [31:0]      stat [2];

  assign ready    = {outa_ready, outb_ready};
  // Depends only on registered occupancy, never on the consumer's ready.
  assign in_ready = in_sel ? !full[1] : !full[0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [AW-1:0]    wr_q, wr_d;
      logic [AW-1:0]    rd_q, rd_d;
      logic [AW:0]      count_q, count_d;
      logic [WIDTH-1:0] mem_q [DEPTH];

      assign push[gi]  = in_valid && in_ready && ((gi == 1) ? in_sel : !in_sel);
      assign pop[gi]   = valid[gi] && ready[gi];
      assign full[gi]  = (count_q == (AW+1)'(DEPTH));
      assign valid[gi] = (count_q != '0);
      assign head[gi]  = valid[gi] ? mem_q[rd_q] : '0;

      always_comb begin
        wr_d    = push[gi] ? wr_q + 1'b1 : wr_q;
        rd_d    = pop[gi] ? rd_q + 1'b1 : rd_q;
        count_d = count_q + {{AW{1'b0}}, push[gi]} - {{AW{1'b0}}, pop[gi]};
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_q    <= '0;
          rd_q    <= '0;
          count_q <= '0;
        end else begin
          wr_q    <= wr_d;
          rd_q    <= rd_d;
          count_q <= count_d;
        end
      end

      // Payload storage needs no reset; empty entries are masked by valid.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem_q[wr_q] <= in_data;
        end
      end

`ifdef DEMUX_STATS_EN
      logic [31:0] cnt_q, cnt_d;

      assign cnt_d = cnt_q + 32'd1;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else if (pop[gi]) begin
          cnt_q <= cnt_d;
        end
      end

      assign stat[gi] = cnt_q;
`else
      assign stat[gi] = '0;
`endif
    end
  endgenerate

  assign outa_data  = head[1];
  assign outa_valid = valid[1];
  assign outb_data  = head[0];
  assign outb_valid = valid[0];
  assign cnt_a      = stat[1];
  assign cnt_b      = stat[0];

endmodule
